// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-side bus bundle for mem_bus_arbiter.
// Index 0 of every two-entry field is the instruction cache, index 1 the data cache.
interface mem_bus_arbiter_if #(
  parameter int LINE_ADDR_WIDTH = 28,
  parameter int LINE_WIDTH      = 128
);
  logic [1:0]                            req_available;
  logic [1:0]                            req_read;
  logic [1:0]                            req_write;
  logic [1:0][LINE_ADDR_WIDTH-1:0]       req_addr;
  logic [1:0][LINE_WIDTH-1:0]            req_data;
  logic [1:0]                            rsp_valid;
  logic [1:0][LINE_ADDR_WIDTH-1:0]       rsp_addr;
  logic [1:0][LINE_WIDTH-1:0]            rsp_data;
  logic                                  mem_req_valid;
  logic                                  mem_req_write;
  logic [LINE_ADDR_WIDTH-1:0]            mem_req_addr;
  logic [LINE_WIDTH-1:0]                 mem_req_data;
  logic                                  mem_req_ready;
  logic                                  mem_rsp_valid;
  logic [LINE_ADDR_WIDTH-1:0]            mem_rsp_addr;
  logic [LINE_WIDTH-1:0]                 mem_rsp_data;

  modport master (
    output req_available, rsp_valid, rsp_addr, rsp_data,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  req_read, req_write, req_addr, req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_data
  );

  modport slave (
    input  req_available, rsp_valid, rsp_addr, rsp_data,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output req_read, req_write, req_addr, req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-cache line-port arbiter: strict G0/G1 alternation, in-order read-tag FIFO,
// and one-cycle registered routing of memory fill responses back to the issuing cache.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  mem_bus_arbiter_if.master                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unmatched
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {G0 = 1'b0, G1 = 1'b1} grant_e;

  grant_e                     state_r;
  logic [MAX_OUTSTANDING-1:0] tag_r;
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [CNT_W-1:0]           count_r;
  logic                       err_r;

  logic owner_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic stall_s;
  logic fwd_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  // Grant decode and forwarding; grants never look at the request lines.
  always_comb begin
    owner_s      = (state_r == G1);
    fifo_full_s  = (count_r == CNT_W'(MAX_OUTSTANDING));
    fifo_empty_s = (count_r == {CNT_W{1'b0}});
    stall_s      = ~bus.mem_req_ready | fifo_full_s;
    fwd_s        = ~stall_s & (bus.req_read[owner_s] | bus.req_write[owner_s]);
    push_s       = fwd_s & ~bus.req_write[owner_s];
    pop_s        = bus.mem_rsp_valid & ~fifo_empty_s;
    head_s       = tag_r[rd_ptr_r];
  end

  assign bus.req_available = {owner_s & ~stall_s, ~owner_s & ~stall_s};
  assign bus.mem_req_valid = fwd_s;
  assign bus.mem_req_write = bus.req_write[owner_s];
  assign bus.mem_req_addr  = bus.req_addr[owner_s];
  assign bus.mem_req_data  = bus.req_data[owner_s];
  assign outstanding       = count_r;
  assign err_unmatched     = err_r;

  // Grant FSM: hold while stalled, otherwise alternate owners every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= G0;
    end else if (stall_s) begin
      state_r <= state_r;
    end else begin
      case (state_r)
        G0:      state_r <= G1;
        G1:      state_r <= G0;
        default: state_r <= G0;
      endcase
    end
  end

  // Read-tag FIFO; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_r    <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tag_r[wr_ptr_r] <= owner_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Response routing; an unmatched response only raises the sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rsp_valid <= 2'b00;
      bus.rsp_addr  <= '0;
      bus.rsp_data  <= '0;
      err_r         <= 1'b0;
    end else begin
      if (pop_s) begin
        bus.rsp_valid         <= 2'b01 << head_s;
        bus.rsp_addr[head_s]  <= bus.mem_rsp_addr;
        bus.rsp_data[head_s]  <= bus.mem_rsp_data;
      end else begin
        bus.rsp_valid <= 2'b00;
      end
      err_r <= err_r | (bus.mem_rsp_valid & fifo_empty_s);
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, a reference model built on a
// tag queue, and randomized traffic checked cycle by cycle against that model.
module tb_mem_bus_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MO = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] outstanding;
  logic          err_unmatched;

  always #5 clock = ~clock;

  mem_bus_arbiter_if #(.LINE_ADDR_WIDTH(AW), .LINE_WIDTH(DW)) bus ();

  mem_bus_arbiter #(.MAX_OUTSTANDING(MO)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .outstanding   (outstanding),
    .err_unmatched (err_unmatched)
  );

  typedef struct {
    logic [1:0]    rd;
    logic [1:0]    wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          ready;
    logic          rspv;
    logic [AW-1:0] raddr;
    logic [1:0]    e_av;
    logic          e_mv;
    logic [1:0]    e_rv;
    logic [CW-1:0] e_out;
    logic          e_err;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: owner, queue of requester IDs for reads in flight, sticky error.
  int            m_owner;
  int            tagq[$];
  bit            m_err;
  logic [1:0]    m_rv;
  logic [AW-1:0] m_ra [2];
  logic [DW-1:0] m_rd [2];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    tagq.delete();
    m_err   = 1'b0;
    m_rv    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_ra[i] = '0;
      m_rd[i] = '0;
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic ready, input logic rspv, input logic [AW-1:0] raddr,
                              input logic [1:0] e_av, input logic e_mv, input logic [1:0] e_rv,
                              input logic [CW-1:0] e_out, input logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.ready = ready; v.rspv = rspv;
    v.raddr = raddr; v.e_av = e_av; v.e_mv = e_mv; v.e_rv = e_rv; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  // One bus cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic ready, input logic rspv,
                       input logic [AW-1:0] raddr, input logic [DW-1:0] rdata,
                       output logic [1:0] got_av, output logic got_mv, output logic [1:0] got_rv,
                       output logic [CW-1:0] got_out, output logic got_err);
    bit         stall;
    bit         exp_mv;
    logic [1:0] exp_av;
    logic [1:0] nv;
    int         o;
    int         h;
    @(negedge clock);
    bus.req_read      = rd;
    bus.req_write     = wr;
    bus.req_addr[0]   = a0;
    bus.req_addr[1]   = a1;
    bus.req_data[0]   = d0;
    bus.req_data[1]   = d1;
    bus.mem_req_ready = ready;
    bus.mem_rsp_valid = rspv;
    bus.mem_rsp_addr  = raddr;
    bus.mem_rsp_data  = rdata;
    #1;
    o      = m_owner;
    stall  = !ready || (tagq.size() == MO);
    exp_av = stall ? 2'b00 : ((o == 1) ? 2'b10 : 2'b01);
    exp_mv = !stall && (rd[o] || wr[o]);
    got_av = bus.req_available;
    got_mv = bus.mem_req_valid;
    chk("model_req_available", DW'(bus.req_available), DW'(exp_av));
    chk("model_mem_req_valid", DW'(bus.mem_req_valid), DW'(exp_mv));
    if (exp_mv) begin
      chk("model_mem_req_write", DW'(bus.mem_req_write), DW'(wr[o]));
      chk("model_mem_req_addr", DW'(bus.mem_req_addr), DW'((o == 1) ? a1 : a0));
      chk("model_mem_req_data", bus.mem_req_data, (o == 1) ? d1 : d0);
    end
    nv = 2'b00;
    if (rspv) begin
      if (tagq.size() > 0) begin
        h       = tagq.pop_front();
        nv[h]   = 1'b1;
        m_ra[h] = raddr;
        m_rd[h] = rdata;
      end else begin
        m_err = 1'b1;
      end
    end
    m_rv = nv;
    if (exp_mv && !wr[o]) tagq.push_back(o);
    if (!stall) m_owner = 1 - m_owner;
    @(posedge clock);
    #1;
    got_rv  = bus.rsp_valid;
    got_out = outstanding;
    got_err = err_unmatched;
    chk("model_rsp_valid", DW'(bus.rsp_valid), DW'(m_rv));
    for (int i = 0; i < 2; i++) begin
      chk("model_rsp_addr", DW'(bus.rsp_addr[i]), DW'(m_ra[i]));
      chk("model_rsp_data", bus.rsp_data[i], m_rd[i]);
    end
    chk("model_outstanding", DW'(outstanding), DW'(tagq.size()));
    chk("model_err_unmatched", DW'(err_unmatched), DW'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset             = 1'b1;
    bus.req_read      = 2'b00;
    bus.req_write     = 2'b00;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset_outstanding", DW'(outstanding), DW'(0));
    chk("reset_err_unmatched", DW'(err_unmatched), DW'(0));
    chk("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    for (int i = 0; i < 2; i++) begin
      chk("reset_rsp_addr", DW'(bus.rsp_addr[i]), DW'(0));
      chk("reset_rsp_data", bus.rsp_data[i], DW'(0));
    end
  endtask

  vec_t          tbl[$];
  vec_t          v;
  logic [1:0]    g_av;
  logic          g_mv;
  logic [1:0]    g_rv;
  logic [CW-1:0] g_out;
  logic          g_err;
  logic [DW-1:0] d_ones;
  logic [DW-1:0] d_one;
  logic [DW-1:0] rdat;
  logic [AW-1:0] z;

  initial begin
    d_ones = '1;
    d_one  = {4{32'h5A5A_0F0F}};
    z      = '0;
    bus.req_read = 2'b00; bus.req_write = 2'b00;
    bus.req_addr = '0; bus.req_data = '0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_addr = '0; bus.mem_rsp_data = '0;

    //                rd     wr     a0         a1        rdy   rspv  raddr      e_av   mv    e_rv   out   err
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b01, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b10, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b01, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, z,         28'h0000123, 1'b1, 1'b0, z,       2'b10, 1'b1, 2'b00, 3'd1, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b01, 1'b0, 2'b00, 3'd1, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b10, 1'b0, 2'b00, 3'd1, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b1, 28'h0000123, 2'b01, 1'b0, 2'b10, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b10, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 28'h10,    z,         1'b1, 1'b0, z,         2'b01, 1'b1, 2'b00, 3'd1, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, z,         28'h20,    1'b1, 1'b0, z,         2'b10, 1'b1, 2'b00, 3'd2, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 28'h30,    z,         1'b1, 1'b0, z,         2'b01, 1'b1, 2'b00, 3'd3, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, z,         28'h40,    1'b1, 1'b0, z,         2'b10, 1'b1, 2'b00, 3'd4, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b00, 1'b0, 2'b00, 3'd4, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b1, 28'h10,    2'b00, 1'b0, 2'b01, 3'd3, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b1, 28'h20,    2'b01, 1'b0, 2'b10, 3'd2, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b1, 28'h30,    2'b10, 1'b0, 2'b01, 3'd1, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b1, 28'h40,    2'b01, 1'b0, 2'b10, 3'd0, 1'b0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(2'b00, 2'b00, z,       z,         1'b0, 1'b0, z,         2'b00, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b10, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b01, 28'h55,    z,         1'b1, 1'b0, z,         2'b01, 1'b1, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b10, 1'b0, 2'b00, 3'd0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b1, 28'h77,    2'b01, 1'b0, 2'b00, 3'd0, 1'b1));
    tbl.push_back(mk(2'b00, 2'b00, z,         z,         1'b1, 1'b0, z,         2'b10, 1'b0, 2'b00, 3'd0, 1'b1));
    tbl.push_back(mk(2'b01, 2'b00, 28'h100,   z,         1'b1, 1'b0, z,         2'b01, 1'b1, 2'b00, 3'd1, 1'b1));
    tbl.push_back(mk(2'b10, 2'b00, z,         28'h200,   1'b1, 1'b0, z,         2'b10, 1'b1, 2'b00, 3'd2, 1'b1));

    do_reset();

    for (int k = 0; k < tbl.size(); k++) begin
      v    = tbl[k];
      rdat = (v.raddr == 28'h0000123) ? {16{8'hA5}} : {4{4'hA, v.raddr}};
      cycle(v.rd, v.wr, v.a0, v.a1, d_ones, d_one, v.ready, v.rspv, v.raddr, rdat,
            g_av, g_mv, g_rv, g_out, g_err);
      chk($sformatf("vec%0d_req_available", k), DW'(g_av), DW'(v.e_av));
      chk($sformatf("vec%0d_mem_req_valid", k), DW'(g_mv), DW'(v.e_mv));
      chk($sformatf("vec%0d_rsp_valid", k), DW'(g_rv), DW'(v.e_rv));
      chk($sformatf("vec%0d_outstanding", k), DW'(g_out), DW'(v.e_out));
      chk($sformatf("vec%0d_err_unmatched", k), DW'(g_err), DW'(v.e_err));
    end

    // Reset with two reads in flight clears the FIFO and the sticky error, grant restarts at G0.
    do_reset();
    chk("post_reset_outstanding", DW'(outstanding), DW'(0));
    cycle(2'b00, 2'b00, z, z, d_ones, d_one, 1'b1, 1'b0, z, '0, g_av, g_mv, g_rv, g_out, g_err);
    chk("post_reset_grant_g0", DW'(g_av), DW'(2'b01));

    // A read pushed in the same cycle as a stray response does not match it.
    cycle(2'b00, 2'b00, z, z, d_ones, d_one, 1'b1, 1'b0, z, '0, g_av, g_mv, g_rv, g_out, g_err);
    cycle(2'b01, 2'b00, 28'h3, z, d_ones, d_one, 1'b1, 1'b1, 28'h9, {4{32'h1}},
          g_av, g_mv, g_rv, g_out, g_err);
    chk("push_vs_unmatched_rsp_valid", DW'(g_rv), DW'(0));
    chk("push_vs_unmatched_err", DW'(g_err), DW'(1));
    chk("push_vs_unmatched_out", DW'(g_out), DW'(1));

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      logic [1:0] rr;
      logic [1:0] ww;
      logic       rsp;
      rr  = 2'($urandom);
      ww  = 2'($urandom) & 2'($urandom) & 2'($urandom);
      rsp = (tagq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      cycle(rr, ww, AW'($urandom), AW'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 4) != 0), rsp, AW'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, g_av, g_mv, g_rv, g_out, g_err);
      if (k == 400) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one main-memory line port between two write-back line caches: requester 0 is the instruction cache and requester 1 is the data cache.
- Each cache issues line reads and write-backs only in a cycle where its `available` input is high.
- The arbiter forwards the request to memory and records the requester ID of each outstanding read in an in-order tag FIFO.
- It routes each memory response back to the cache that issued the read, with one cycle of latency.

Parameters:
- LINE_ADDR_WIDTH, 28, line address width (physical address width 32 minus log2(16 bytes per line)).
- LINE_WIDTH, 128, line data width in bits.
- MAX_OUTSTANDING, 4, depth of the read-tag FIFO; power of two, at least 2.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_available[2]  out  1 each  bus grant to cache i
- req_read[2]  in  1 each  line read request; legal only while req_available[i]
- req_write[2]  in  1 each  line write-back; legal only while req_available[i]
- req_addr[2]  in  LINE_ADDR_WIDTH each  line address
- req_data[2]  in  LINE_WIDTH each  write-back data
- rsp_valid[2]  out  1 each  fill response to cache i
- rsp_addr[2]  out  LINE_ADDR_WIDTH each  fill line address
- rsp_data[2]  out  LINE_WIDTH each  fill data
- mem_req_valid  out  1  request to memory
- mem_req_write  out  1  1 = write, 0 = read
- mem_req_addr  out  LINE_ADDR_WIDTH
- mem_req_data  out  LINE_WIDTH
- mem_req_ready  in  1  memory accepts this cycle; must not depend combinationally on mem_req_valid
- mem_rsp_valid  in  1  read data returning; responses arrive in request order
- mem_rsp_addr  in  LINE_ADDR_WIDTH
- mem_rsp_data  in  LINE_WIDTH
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
- err_unmatched  out  1  sticky: a response arrived with the tag FIFO empty

Behaviour:
- Reset:
  - grant FSM goes to G0, FIFO is emptied, outstanding=0, err_unmatched=0.
  - All rsp_valid=0, all rsp_addr/rsp_data=0.
- Grant FSM has two states, G0 and G1 (owner = requester 0 or 1).
- `stall` = ~mem_req_ready | fifo_full.
- req_available[i] = (state==Gi) & ~stall. It is combinational from registers plus mem_req_ready only, and never depends on req_read/req_write. At most one grant is high per cycle.
- Transitions:
  - stall → hold state.
  - no stall → toggle (G0↔G1) every cycle, whether or not the owner issued a request. This gives strict alternation, and worst-case grant wait is 1 cycle plus the stall duration.
- Forwarding, with o = owner:
  - mem_req_valid = req_available[o] & (req_read[o] | req_write[o]).
  - mem_req_write = req_write[o]; mem_req_addr/data = req_addr/data[o].
  - If req_read and req_write are both high, the write wins and the read is ignored.
- Requests from the non-owner are ignored; they are illegal and produce no memory request.
- Tag FIFO:
  - Push o when the forwarded request is a read.
  - Pop on mem_rsp_valid.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - A push cannot occur while full, because the grant is blocked.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Writes are fire-and-forget: no tag is pushed and no response is expected.
- Response routing:
  - On mem_rsp_valid with FIFO non-empty: next cycle rsp_valid[head]=1 and rsp_addr/data[head] = the registered mem_rsp_addr/data.
  - The other requester's rsp_valid=0. rsp_valid is a one-cycle pulse.
- Unmatched response: mem_rsp_valid with FIFO empty → response dropped, no rsp_valid, err_unmatched set until reset. A simultaneous push does not satisfy it.
- outstanding = FIFO count, updated at the clock edge.
- Reset mid-operation: the FIFO is cleared. Memory must be reset in the same cycle. Any response arriving afterwards is treated as unmatched.

Test Plan:
- Reset, then idle: grant alternates G0,G1,G0… each cycle; mem_req_valid=0; outstanding=0; err_unmatched=0.
- Cache 1 read at 0x0000123 in a G1 cycle; memory returns 3 cycles later with data 0xA5…A5 → mem_req_valid=1 & write=0 in the grant cycle; rsp_valid[1]=1, addr 0x0000123, data 0xA5…A5 one cycle after mem_rsp_valid; rsp_valid[0] stays 0.
- Reads alternate I(0x10), D(0x20), I(0x30), D(0x40), with responses returned in order → routed 0,1,0,1 with matching addresses; outstanding peaks at 4; in that cycle both req_available are 0 until the first response pops.
- mem_req_ready=0 for 5 cycles while in G1 → no grants, state held at G1; on ready=1, req_available[1]=1 first.
- Write-back from cache 0 (addr 0x55, data all ones) → mem_req_write=1; outstanding unchanged; no rsp_valid.
- mem_rsp_valid with FIFO empty → no rsp_valid, err_unmatched=1 and stays 1 until reset; reset with 2 reads outstanding → outstanding=0 and grant at G0 next cycle.
